// File: rtl/pc_gen.sv
// PC register, next-PC select and fetch handshake for the NPC core.
// Optional return-address stack enabled by defining PC_RAS_EN.
module pc_gen #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = 32'h80000000,
  parameter int              RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic            pc_valid,
  input  logic            pc_ready,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] next_pc,
  input  logic            br_take,
  input  logic            jalr_take,
  input  logic [XLEN-1:0] pc_ex,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1,
  input  logic            trap,
  input  logic [XLEN-1:0] mtvec,
  input  logic            mret,
  input  logic [XLEN-1:0] mepc,
  output logic            misalign,
  output logic [XLEN-1:0] misalign_addr,
  input  logic            is_call,
  input  logic            is_ret,
  output logic [XLEN-1:0] ras_top,
  output logic            ras_empty
);

  logic [XLEN-1:0] r_pc;
  logic            r_valid;
  logic            r_mis;
  logic [XLEN-1:0] r_mis_addr;

  logic [XLEN-1:0] w_br_tgt;
  logic [XLEN-1:0] w_jalr_tgt;
  logic [XLEN-1:0] w_tvec;
  logic [XLEN-1:0] w_epc;
  logic [XLEN-1:0] w_next;
  logic            w_mis_set;
  logic [XLEN-1:0] w_mis_tgt;

  assign w_br_tgt   = pc_ex + imm;
  assign w_jalr_tgt = (rs1 + imm) & ~XLEN'(1);
  assign w_tvec     = mtvec & ~XLEN'(3);
  assign w_epc      = mepc & ~XLEN'(3);

  // Prioritised next-PC select; misaligned br/jalr targets hold the PC.
  always_comb begin
    w_next    = r_pc;
    w_mis_set = 1'b0;
    w_mis_tgt = '0;
    if (trap) begin
      w_next = w_tvec;
    end else if (mret) begin
      w_next = w_epc;
    end else if (jalr_take) begin
      if (w_jalr_tgt[1:0] != 2'b00) begin
        w_mis_set = 1'b1;
        w_mis_tgt = w_jalr_tgt;
      end else begin
        w_next = w_jalr_tgt;
      end
    end else if (br_take) begin
      if (w_br_tgt[1:0] != 2'b00) begin
        w_mis_set = 1'b1;
        w_mis_tgt = w_br_tgt;
      end else begin
        w_next = w_br_tgt;
      end
    end else if (r_valid && pc_ready) begin
      w_next = r_pc + XLEN'(4);
    end
  end

  // PC, valid and misalign state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= RESET_VEC;
      r_valid    <= 1'b0;
      r_mis      <= 1'b0;
      r_mis_addr <= '0;
    end else begin
      r_pc    <= w_next;
      r_valid <= 1'b1;
      r_mis   <= w_mis_set;
      if (w_mis_set) r_mis_addr <= w_mis_tgt;
    end
  end

  assign pc            = r_pc;
  assign pc_valid      = r_valid;
  assign next_pc       = rst ? RESET_VEC : w_next;
  assign misalign      = r_mis;
  assign misalign_addr = r_mis_addr;

`ifdef PC_RAS_EN
  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CW = $clog2(RAS_DEPTH + 1);

  logic [XLEN-1:0] r_ras [RAS_DEPTH];
  logic [PW-1:0]   r_sp;
  logic [CW-1:0]   r_cnt;
  logic [PW-1:0]   w_top_idx;
  logic [XLEN-1:0] w_link;
  logic            w_has;

  assign w_top_idx = r_sp - PW'(1);
  assign w_link    = pc_ex + XLEN'(4);
  assign w_has     = (r_cnt != '0);

  // Circular return-address stack; oldest entry overwritten when full.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sp  <= '0;
      r_cnt <= '0;
    end else if (!trap) begin
      if (is_call && is_ret && w_has) begin
        r_ras[w_top_idx] <= w_link;
      end else if (is_call) begin
        r_ras[r_sp] <= w_link;
        r_sp        <= r_sp + PW'(1);
        if (r_cnt != CW'(RAS_DEPTH)) r_cnt <= r_cnt + CW'(1);
      end else if (is_ret && w_has) begin
        r_sp  <= r_sp - PW'(1);
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

  assign ras_top   = w_has ? r_ras[w_top_idx] : '0;
  assign ras_empty = !w_has;
`else
  localparam int unused_ras_depth = RAS_DEPTH;
  logic w_unused_ras;
  assign w_unused_ras = is_call ^ is_ret;
  assign ras_top      = '0;
  assign ras_empty    = 1'b1;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen.
// Define PC_RAS_EN to also exercise the return-address stack.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_valid;
  logic        pc_ready;
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic        br_take;
  logic        jalr_take;
  logic [31:0] pc_ex;
  logic [31:0] imm;
  logic [31:0] rs1;
  logic        trap;
  logic [31:0] mtvec;
  logic        mret;
  logic [31:0] mepc;
  logic        misalign;
  logic [31:0] misalign_addr;
  logic        is_call;
  logic        is_ret;
  logic [31:0] ras_top;
  logic        ras_empty;

  int n_chk = 0;
  int n_err = 0;

  pc_gen dut (
    .clk           (clk),
    .rst           (rst),
    .pc_valid      (pc_valid),
    .pc_ready      (pc_ready),
    .pc            (pc),
    .next_pc       (next_pc),
    .br_take       (br_take),
    .jalr_take     (jalr_take),
    .pc_ex         (pc_ex),
    .imm           (imm),
    .rs1           (rs1),
    .trap          (trap),
    .mtvec         (mtvec),
    .mret          (mret),
    .mepc          (mepc),
    .misalign      (misalign),
    .misalign_addr (misalign_addr),
    .is_call       (is_call),
    .is_ret        (is_ret),
    .ras_top       (ras_top),
    .ras_empty     (ras_empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    pc_ready  = 1'b0;
    br_take   = 1'b0;
    jalr_take = 1'b0;
    pc_ex     = '0;
    imm       = '0;
    rs1       = '0;
    trap      = 1'b0;
    mtvec     = '0;
    mret      = 1'b0;
    mepc      = '0;
    is_call   = 1'b0;
    is_ret    = 1'b0;
    step();
    step();
    check("rst_pc", pc, 32'h80000000);
    check("rst_valid", 32'(pc_valid), 32'd0);
    check("rst_mis", 32'(misalign), 32'd0);
    check("rst_mis_addr", misalign_addr, 32'd0);
    check("rst_ras_empty", 32'(ras_empty), 32'd1);
    check("rst_ras_top", ras_top, 32'd0);

    rst      = 1'b0;
    pc_ready = 1'b1;
    step();
    check("first_valid", 32'(pc_valid), 32'd1);
    check("first_pc", pc, 32'h80000000);
    step();
    check("seq_pc1", pc, 32'h80000004);
    step();
    check("seq_pc2", pc, 32'h80000008);
    step();
    step();
    check("seq_pc4", pc, 32'h80000010);

    pc_ready = 1'b0;
    #1;
    check("hold_next", next_pc, 32'h80000010);
    for (int i = 0; i < 4; i++) begin
      step();
      check("hold_pc", pc, 32'h80000010);
      check("hold_valid", 32'(pc_valid), 32'd1);
    end

    pc_ex   = 32'h80000020;
    imm     = 32'hFFFFFFF0;
    br_take = 1'b1;
    #1;
    check("br_next", next_pc, 32'h80000010);
    step();
    check("br_pc", pc, 32'h80000010);

    pc_ex = 32'h80000100;
    imm   = 32'h00000020;
    #1;
    check("br2_next", next_pc, 32'h80000120);
    step();
    check("br2_pc", pc, 32'h80000120);

    pc_ex = 32'hFFFFFFFC;
    imm   = 32'h00000008;
    step();
    check("br_wrap", pc, 32'h00000004);
    br_take  = 1'b0;
    pc_ready = 1'b1;
    step();
    check("wrap_seq", pc, 32'h00000008);
    pc_ready = 1'b0;

    rs1       = 32'h80000101;
    imm       = 32'h00000002;
    jalr_take = 1'b1;
    #1;
    check("jalr_mis_next", next_pc, 32'h00000008);
    step();
    jalr_take = 1'b0;
    check("jalr_mis", 32'(misalign), 32'd1);
    check("jalr_mis_addr", misalign_addr, 32'h80000102);
    check("jalr_mis_pc", pc, 32'h00000008);
    step();
    check("mis_pulse_end", 32'(misalign), 32'd0);
    check("mis_addr_held", misalign_addr, 32'h80000102);

    rs1       = 32'h80000101;
    imm       = 32'h00000000;
    jalr_take = 1'b1;
    step();
    check("jalr_bit0", pc, 32'h80000100);
    check("jalr_bit0_mis", 32'(misalign), 32'd0);

    pc_ex   = 32'h80000000;
    imm     = 32'h00000003;
    br_take = 1'b1;
    jalr_take = 1'b0;
    step();
    br_take = 1'b0;
    check("br_mis", 32'(misalign), 32'd1);
    check("br_mis_addr", misalign_addr, 32'h80000003);
    check("br_mis_pc", pc, 32'h80000100);

    rs1       = 32'h80000101;
    imm       = 32'h00000002;
    pc_ex     = 32'h80000001;
    jalr_take = 1'b1;
    br_take   = 1'b1;
    trap      = 1'b1;
    mtvec     = 32'h80000203;
    step();
    trap      = 1'b0;
    jalr_take = 1'b0;
    br_take   = 1'b0;
    check("trap_pc", pc, 32'h80000200);
    check("trap_no_mis", 32'(misalign), 32'd0);

    mret      = 1'b1;
    mepc      = 32'h80000043;
    br_take   = 1'b1;
    pc_ex     = 32'h80000300;
    imm       = 32'h0;
    step();
    mret    = 1'b0;
    br_take = 1'b0;
    check("mret_pc", pc, 32'h80000040);

    pc_ready = 1'b1;
    step();
    check("post_mret_seq", pc, 32'h80000044);

    rst     = 1'b1;
    br_take = 1'b1;
    pc_ex   = 32'h80000500;
    step();
    rst     = 1'b0;
    br_take = 1'b0;
    check("midrst_pc", pc, 32'h80000000);
    check("midrst_valid", 32'(pc_valid), 32'd0);
    check("midrst_mis_addr", misalign_addr, 32'd0);

`ifdef PC_RAS_EN
    pc_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      is_call = 1'b1;
      pc_ex   = 32'(i * 32'h100);
      step();
    end
    is_call = 1'b0;
    check("ras_top5", ras_top, 32'h504);
    check("ras_nempty", 32'(ras_empty), 32'd0);
    is_ret = 1'b1;
    step();
    check("ras_pop1", ras_top, 32'h404);
    step();
    check("ras_pop2", ras_top, 32'h304);
    step();
    check("ras_pop3", ras_top, 32'h204);
    step();
    check("ras_pop4_empty", 32'(ras_empty), 32'd1);
    check("ras_pop4_top", ras_top, 32'd0);
    step();
    is_ret = 1'b0;
    check("ras_extra_ret", 32'(ras_empty), 32'd1);
`else
    is_call = 1'b1;
    is_ret  = 1'b0;
    pc_ex   = 32'h100;
    step();
    is_call = 1'b0;
    check("noras_empty", 32'(ras_empty), 32'd1);
    check("noras_top", ras_top, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter unit for the NPC core: owns the PC register, selects the next PC among sequential, PC-relative branch/JAL, absolute JALR, trap-vector and trap-return targets, and presents the current PC to the instruction-fetch unit through a valid/ready handshake. It sits between the EXU/CSR redirect sources and the IFU, and replaces the previous combinational next-PC selector plus external PC register.

## Interface
- XLEN, 32, datapath width of PC and all targets
- RESET_VEC, 32'h80000000, PC value loaded by reset
- RAS_DEPTH, 4, return-address-stack entries (used only with PC_RAS_EN; power of 2, ≥2)

- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- pc_valid  output  1  pc holds a fetch request
- pc_ready  input  1  IFU accepts current pc
- pc  output  XLEN  current PC
- next_pc  output  XLEN  combinational value pc will take at next edge
- br_take  input  1  branch/JAL redirect: target = pc_ex + imm
- jalr_take  input  1  JALR redirect: target = (rs1 + imm) & ~1
- pc_ex  input  XLEN  PC of redirecting instruction
- imm  input  XLEN  sign-extended immediate
- rs1  input  XLEN  JALR base
- trap  input  1  exception/interrupt redirect to mtvec
- mtvec  input  XLEN  trap vector (bits[1:0] forced 0)
- mret  input  1  return to mepc
- mepc  input  XLEN  return address (bits[1:0] forced 0)
- misalign  output  1  one-cycle pulse: br/jalr target bits[1:0] ≠ 0
- misalign_addr  output  XLEN  offending target, held until next misalign
- is_call  input  1  RAS push (PC_RAS_EN only), link = pc_ex + 4
- is_ret  input  1  RAS pop (PC_RAS_EN only)
- ras_top  output  XLEN  predicted return address (PC_RAS_EN only)
- ras_empty  output  1  RAS holds no entry (PC_RAS_EN only)

## Operation
- Priority of next_pc: trap → mtvec; else mret → mepc; else jalr_take → JALR target; else br_take → pc_ex + imm; else (pc_valid & pc_ready) → pc + 4; else pc (hold).
- All additions modulo 2^XLEN; wrap-around from all-ones to zero is legal, no flag.
- Misaligned br/jalr target (bits[1:0] ≠ 0; JALR bit0 already cleared): target not taken, pc holds, misalign pulses, misalign_addr captures target. Trap/mret never misalign.
- Redirect is accepted regardless of pc_ready; the pending unaccepted fetch is discarded and pc_valid stays 1 with new pc.
- Simultaneous trap and mret/jalr/br: trap wins; lower sources ignored that cycle, no misalign from them.

## Timing
- Reset: pc = RESET_VEC, pc_valid = 0, misalign = 0, misalign_addr = 0, RAS emptied (ras_empty = 1, ras_top = 0).
- First cycle after rst falls: pc_valid = 1, pc = RESET_VEC.
- Redirect inputs sampled at edge; new pc visible the cycle after (1-cycle latency). next_pc reflects it same cycle.
- pc_valid, once 1, remains 1 until reset; pc only changes on acceptance or redirect.
- rst asserted mid-operation overrides all inputs in that cycle.

## Configuration
- PC_RAS_EN defined: RAS_DEPTH-entry circular return-address stack. is_call pushes pc_ex + 4 (overwrites oldest when full, count saturates); is_ret pops (ignored when empty); simultaneous is_call & is_ret replaces top without changing count. ras_top = top entry, 0 when empty. Pushes/pops occur only in cycles without trap.
- PC_RAS_EN undefined: is_call/is_ret ignored, ras_top tied 0, ras_empty tied 1, no RAS storage.

## Test plan
- Reset release, pc_ready = 1 for 3 cycles → pc sequence 80000000, 80000004, 80000008; pc_valid 0 during reset, 1 after.
- pc_ready = 0 for 4 cycles at pc = 80000010 → pc holds 80000010, pc_valid = 1.
- pc_ex = 80000020, imm = FFFFFFF0, br_take, pc_ready = 0 → next cycle pc = 80000010.
- jalr_take with rs1 = 80000101, imm = 2 → target 80000102 misaligned: misalign pulses 1 cycle, misalign_addr = 80000102, pc unchanged.
- trap, jalr_take, br_take same cycle, mtvec = 80000203 → pc = 80000200; then mret, mepc = 80000040 → pc = 80000040.
- PC_RAS_EN, RAS_DEPTH = 4: 5 calls with pc_ex = 100,200,300,400,500 → ras_top = 504; 4 rets → ras_top sequence 404, 304, 204, then ras_empty = 1; further ret ignored.
